// File: rtl/dds_seq_pkg.sv
// Shared types and constants for the DDS modulation sequencer.
package dds_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LUT_ADDR,
        ST_LUT_WE,
        ST_PRIME,
        ST_RUN
    } state_t;

    localparam logic [1:0]  MODE_CW   = 2'd0;
    localparam logic [1:0]  MODE_FM   = 2'd1;
    localparam logic [1:0]  MODE_AM   = 2'd2;

    localparam logic [15:0] AMPL_FULL = 16'h7FFF;
    localparam logic [1:0]  PATH_LUT  = 2'd3;

endpackage

// File: rtl/dds_mod_ram.sv
// Modulation table: one write port, one synchronous read port, read-before-write.
module dds_mod_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dds_mod_sequencer.sv
// Owns the DDS control inputs: streams the sine LUT in, then plays the
// modulation table as FM or AM at a programmable step rate.
module dds_mod_sequencer
    import dds_seq_pkg::*;
#(
    parameter int LUT_AW = 16,
    parameter int MOD_AW = 8,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lut_load,
    input  logic              lut_valid,
    input  logic [15:0]       lut_data,
    output logic              lut_ready,
    input  logic              mod_we,
    input  logic [MOD_AW-1:0] mod_addr,
    input  logic [15:0]       mod_data,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic              loop,
    input  logic [31:0]       base_freq,
    input  logic [3:0]        fm_shift,
    input  logic [HOLD_W-1:0] hold,
    output logic              busy,
    output logic              done,
    output logic              dds_en,
    output logic [1:0]        dds_path_sel,
    output logic [31:0]       dds_freq,
    output logic [15:0]       dds_ampl_a,
    output logic              dds_lut_we,
    output logic [31:0]       dds_lut_addr,
    output logic [31:0]       dds_lut_data
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t              r_state, w_state_nxt;
    logic [LUT_AW-1:0]   r_lut_cnt, w_lut_cnt_nxt;
    logic [MOD_AW-1:0]   r_idx, w_idx_nxt, w_rd_addr;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt, w_hold_eff;
    logic                w_hold_last, w_tbl_end;
    logic                w_sample, w_done, w_lut_hs, w_load_out;

    logic [1:0]          r_mode;
    logic                r_loop;
    logic [31:0]         r_base;
    logic [3:0]          r_shift;
    logic [HOLD_W-1:0]   r_hold;

    logic signed [15:0]  w_mod_q;
    logic [31:0]         w_freq_nxt;
    logic [15:0]         w_ampl_nxt;

    logic                r_lut_ready, r_busy, r_done, r_dds_en, r_lut_we;
    logic [1:0]          r_path_sel;
    logic [31:0]         r_freq, r_lut_addr, r_lut_data;
    logic [15:0]         r_ampl;

    function automatic logic [31:0] fm_freq(input logic [31:0] base,
                                            input logic signed [15:0] m,
                                            input logic [3:0] sh);
        logic signed [31:0] ext;
        ext = {{16{m[15]}}, m};
        return base + $unsigned(ext >>> sh);
    endfunction

    dds_mod_ram #(
        .AW(MOD_AW),
        .DW(16)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (mod_we),
        .i_waddr (mod_addr),
        .i_wdata (mod_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_mod_q)
    );

    assign w_hold_eff  = (r_hold == '0) ? HOLD_ONE : r_hold;
    assign w_hold_last = (r_hold_cnt == w_hold_eff);
    assign w_tbl_end   = (r_idx == '1);

    // Read address leads the displayed index so the entry is in w_mod_q on its last hold count.
    always_comb begin
        w_rd_addr = '0;
        case (r_state)
            ST_PRIME: w_rd_addr = MOD_AW'(1);
            ST_RUN:   w_rd_addr = r_idx + ((w_hold_eff == HOLD_ONE) ? MOD_AW'(2) : MOD_AW'(1));
            default:  w_rd_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lut_cnt_nxt  = r_lut_cnt;
        w_idx_nxt      = r_idx;
        w_hold_cnt_nxt = r_hold_cnt;
        w_sample       = 1'b0;
        w_done         = 1'b0;
        w_lut_hs       = 1'b0;
        w_load_out     = 1'b0;
        if (r_state != ST_IDLE && stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lut_load) begin
                        w_state_nxt   = ST_LUT_ADDR;
                        w_lut_cnt_nxt = '0;
                    end else if (start) begin
                        w_state_nxt = ST_PRIME;
                        w_sample    = 1'b1;
                    end
                end
                ST_LUT_ADDR: begin
                    if (lut_valid) begin
                        w_lut_hs    = 1'b1;
                        w_state_nxt = ST_LUT_WE;
                    end
                end
                ST_LUT_WE: begin
                    w_lut_cnt_nxt = r_lut_cnt + 1'b1;
                    if (r_lut_cnt == '1) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LUT_ADDR;
                    end
                end
                ST_PRIME: begin
                    w_state_nxt    = ST_RUN;
                    w_idx_nxt      = '0;
                    w_hold_cnt_nxt = HOLD_ONE;
                    w_load_out     = 1'b1;
                end
                ST_RUN: begin
                    if (w_hold_last) begin
                        w_hold_cnt_nxt = HOLD_ONE;
                        if (w_tbl_end && !r_loop) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_idx_nxt  = r_idx + 1'b1;
                            w_load_out = 1'b1;
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_freq_nxt = r_freq;
        w_ampl_nxt = r_ampl;
        if (w_state_nxt != ST_RUN) begin
            w_freq_nxt = r_base;
            w_ampl_nxt = AMPL_FULL;
        end else if (w_load_out) begin
            case (r_mode)
                MODE_FM: begin
                    w_freq_nxt = fm_freq(r_base, w_mod_q, r_shift);
                    w_ampl_nxt = AMPL_FULL;
                end
                MODE_AM: begin
                    w_freq_nxt = r_base;
                    w_ampl_nxt = w_mod_q;
                end
                default: begin
                    w_freq_nxt = r_base;
                    w_ampl_nxt = AMPL_FULL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lut_cnt   <= '0;
            r_idx       <= '0;
            r_hold_cnt  <= '0;
            r_mode      <= MODE_CW;
            r_loop      <= 1'b0;
            r_base      <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_lut_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dds_en    <= 1'b0;
            r_lut_we    <= 1'b0;
            r_path_sel  <= '0;
            r_freq      <= '0;
            r_ampl      <= AMPL_FULL;
            r_lut_addr  <= '0;
            r_lut_data  <= '0;
        end else begin
            r_lut_cnt   <= w_lut_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            if (w_sample) begin
                r_mode  <= mode;
                r_loop  <= loop;
                r_base  <= base_freq;
                r_shift <= fm_shift;
                r_hold  <= hold;
            end
            r_lut_ready <= (w_state_nxt == ST_LUT_ADDR);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done;
            r_dds_en    <= (w_state_nxt == ST_RUN);
            r_lut_we    <= (w_state_nxt == ST_LUT_WE);
            r_path_sel  <= (w_state_nxt == ST_RUN) ? PATH_LUT : 2'd0;
            r_freq      <= w_freq_nxt;
            r_ampl      <= w_ampl_nxt;
            if (w_lut_hs) begin
                r_lut_addr <= 32'(r_lut_cnt);
                r_lut_data <= {16'h0000, lut_data};
            end
        end
    end

    assign lut_ready    = r_lut_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign dds_en       = r_dds_en;
    assign dds_path_sel = r_path_sel;
    assign dds_freq     = r_freq;
    assign dds_ampl_a   = r_ampl;
    assign dds_lut_we   = r_lut_we;
    assign dds_lut_addr = r_lut_addr;
    assign dds_lut_data = r_lut_data;

endmodule

// File: tb/tb_dds_mod_sequencer.sv
// Scoreboard bench: drivers push expected LUT writes and playback samples, a monitor pops and compares.
module tb_dds_mod_sequencer;

    localparam int LUT_AW = 7;
    localparam int MOD_AW = 8;
    localparam int HOLD_W = 16;
    localparam int NLUT   = 1 << LUT_AW;
    localparam int NTBL   = 1 << MOD_AW;

    logic              clk;
    logic              rst;
    logic              lut_load, lut_valid;
    logic [15:0]       lut_data;
    logic              lut_ready;
    logic              mod_we;
    logic [MOD_AW-1:0] mod_addr;
    logic [15:0]       mod_data;
    logic              start, stop;
    logic [1:0]        mode;
    logic              loop;
    logic [31:0]       base_freq;
    logic [3:0]        fm_shift;
    logic [HOLD_W-1:0] hold;
    logic              busy, done, dds_en, dds_lut_we;
    logic [1:0]        dds_path_sel;
    logic [31:0]       dds_freq, dds_lut_addr, dds_lut_data;
    logic [15:0]       dds_ampl_a;

    dds_mod_sequencer #(
        .LUT_AW(LUT_AW),
        .MOD_AW(MOD_AW),
        .HOLD_W(HOLD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lut_load     (lut_load),
        .lut_valid    (lut_valid),
        .lut_data     (lut_data),
        .lut_ready    (lut_ready),
        .mod_we       (mod_we),
        .mod_addr     (mod_addr),
        .mod_data     (mod_data),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .loop         (loop),
        .base_freq    (base_freq),
        .fm_shift     (fm_shift),
        .hold         (hold),
        .busy         (busy),
        .done         (done),
        .dds_en       (dds_en),
        .dds_path_sel (dds_path_sel),
        .dds_freq     (dds_freq),
        .dds_ampl_a   (dds_ampl_a),
        .dds_lut_we   (dds_lut_we),
        .dds_lut_addr (dds_lut_addr),
        .dds_lut_data (dds_lut_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } lut_t;

    typedef struct {
        logic [31:0] freq;
        logic [15:0] ampl;
    } play_t;

    lut_t        lut_q[$];
    play_t       play_q[$];
    int          tbl[NTBL];
    int          n_chk    = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] exp_base = 32'd0;
    lut_t        m_lut;
    play_t       m_play;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    endtask

    // Expected DDS output for one table entry, straight from the mode rules.
    function automatic play_t model(input int m, input int md, input logic [31:0] base, input int sh);
        play_t p;
        int    div, d;
        p.freq = base;
        p.ampl = 16'h7FFF;
        if (md == 1) begin
            div = 1 << sh;
            d = (m >= 0) ? (m / div) : -((-m + div - 1) / div);
            p.freq = base + 32'(d);
        end else if (md == 2) begin
            p.ampl = 16'(m);
        end
        return p;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) done_cnt++;
            if (dds_lut_we === 1'b1) begin
                if (lut_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL lut_we_unexpected: got we=1 at addr %h, expected no write", dds_lut_addr);
                end else begin
                    m_lut = lut_q.pop_front();
                    chk("lut_addr", dds_lut_addr, m_lut.addr);
                    chk("lut_data", dds_lut_data, m_lut.data);
                end
            end
            if (dds_en === 1'b1) begin
                if (play_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL play_unexpected: got dds_en=1 freq %h, expected idle", dds_freq);
                end else begin
                    m_play = play_q.pop_front();
                    chk("play_freq", dds_freq, m_play.freq);
                    chk("play_ampl", 32'(dds_ampl_a), 32'(m_play.ampl));
                    chk("play_path", 32'(dds_path_sel), 32'd3);
                end
            end
            if (busy === 1'b0) begin
                chk("idle_freq", dds_freq, exp_base);
                chk("idle_ampl", 32'(dds_ampl_a), 32'h7FFF);
                chk("idle_en", 32'(dds_en), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_lut_ready", 32'(lut_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_en", 32'(dds_en), 0);
        chk("rst_we", 32'(dds_lut_we), 0);
        chk("rst_path", 32'(dds_path_sel), 0);
        chk("rst_freq", dds_freq, 0);
        chk("rst_ampl", 32'(dds_ampl_a), 32'h7FFF);
        chk("rst_lut_addr", dds_lut_addr, 0);
        chk("rst_lut_data", dds_lut_data, 0);
    endtask

    task automatic write_tbl();
        for (int j = 0; j < NTBL; j++) begin
            mod_we   = 1'b1;
            mod_addr = MOD_AW'(j);
            mod_data = 16'(tbl[j]);
            tick();
        end
        mod_we = 1'b0;
    endtask

    task automatic rand_tbl();
        logic signed [15:0] v;
        for (int j = 0; j < NTBL; j++) begin
            v = 16'($urandom);
            tbl[j] = v;
        end
    endtask

    task automatic scramble_cfg();
        mode      = 2'($urandom);
        loop      = 1'($urandom);
        base_freq = $urandom;
        fm_shift  = 4'($urandom);
        hold      = HOLD_W'($urandom_range(0, 5));
    endtask

    // nwords accepted then either wait for done or issue stop.
    task automatic load(input int stop_at, input bit with_start, input bit start_mid);
        int   cnt, cyc, k;
        bit   acc;
        lut_t e;
        lut_load = 1'b1;
        start    = with_start;
        tick();
        lut_load = 1'b0;
        start    = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < stop_at && cyc < 20 * NLUT) begin
            lut_valid = ($urandom_range(0, 3) != 0);
            lut_data  = 16'($urandom);
            start     = (start_mid && cyc == 10);
            @(negedge clk);
            acc = lut_valid && lut_ready;
            if (acc) begin
                e.addr = 32'(cnt);
                e.data = {16'h0000, lut_data};
                lut_q.push_back(e);
                cnt++;
            end
            tick();
            cyc++;
        end
        lut_valid = 1'b0;
        start     = 1'b0;
        chk("load_words", cnt, stop_at);
        if (stop_at < NLUT) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            repeat (10) tick();
        end else begin
            k = 0;
            while (busy !== 1'b0 && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("load_idle", 32'(busy), 0);
            tick();
            exp_done++;
        end
        chk("load_drained", lut_q.size(), 0);
        chk("load_done_cnt", done_cnt, exp_done);
    endtask

    task automatic play_once(input int md, input logic [31:0] base, input int sh, input int hd);
        int heff, k;
        heff = (hd == 0) ? 1 : hd;
        for (int j = 0; j < NTBL; j++)
            for (int r = 0; r < heff; r++)
                play_q.push_back(model(tbl[j], md, base, sh));
        mode = 2'(md); loop = 1'b0; base_freq = base; fm_shift = 4'(sh); hold = HOLD_W'(hd);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_base = base;
        scramble_cfg();
        @(negedge clk);
        chk("prime_en", 32'(dds_en), 0);
        @(negedge clk);
        chk("run_en", 32'(dds_en), 1);
        k = 2;
        while (done !== 1'b1 && k < NTBL * heff + 20) begin
            @(negedge clk);
            k++;
        end
        chk("done_time", k, NTBL * heff + 2);
        chk("play_drained", play_q.size(), 0);
        tick();
        exp_done++;
        chk("play_done_cnt", done_cnt, exp_done);
    endtask

    // Looping playback of n_run RUN cycles, ended by stop or rst.
    task automatic play_loop(input int md, input logic [31:0] base, input int sh, input int hd,
                             input int n_run, input bit use_rst);
        int heff;
        heff = (hd == 0) ? 1 : hd;
        for (int c = 0; c < n_run; c++)
            play_q.push_back(model(tbl[(c / heff) % NTBL], md, base, sh));
        mode = 2'(md); loop = 1'b1; base_freq = base; fm_shift = 4'(sh); hold = HOLD_W'(hd);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_base = base;
        scramble_cfg();
        @(negedge clk);
        chk("prime_en", 32'(dds_en), 0);
        @(negedge clk);
        chk("run_en", 32'(dds_en), 1);
        repeat (n_run - 1) @(posedge clk);
        #1;
        if (use_rst) begin
            rst = 1'b1;
            exp_base = 32'd0;
        end else begin
            stop = 1'b1;
        end
        tick();
        rst  = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        chk("stop_en", 32'(dds_en), 0);
        chk("stop_ampl", 32'(dds_ampl_a), 32'h7FFF);
        chk("loop_drained", play_q.size(), 0);
        if (use_rst) chk_reset_vals();
        tick();
        chk("loop_done_cnt", done_cnt, exp_done);
    endtask

    initial begin
        rst = 1'b1; lut_load = 0; lut_valid = 0; lut_data = '0; mod_we = 0; mod_addr = '0;
        mod_data = '0; start = 0; stop = 0; mode = '0; loop = 0; base_freq = '0;
        fm_shift = '0; hold = '0;
        repeat (3) tick();
        mon_en = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        tick();
        rst = 1'b0;

        load(NLUT, 1'b0, 1'b0);

        for (int j = 0; j < NTBL; j++) tbl[j] = j * 64;
        write_tbl();
        play_once(1, 32'd30000, 2, 3);

        rand_tbl();
        tbl[0] = -32768;
        write_tbl();
        play_once(2, $urandom, 0, 0);

        for (int i = 0; i < 4; i++) begin
            rand_tbl();
            write_tbl();
            play_once(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)));
        end

        play_loop(1, $urandom, int'($urandom_range(0, 15)), 1, 600, 1'b0);

        load(100, 1'b1, 1'b1);
        load(NLUT, 1'b0, 1'b0);

        play_loop(2, $urandom, 0, 2, 300, 1'b1);
        play_once(3, $urandom, 5, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
